fetch_ctrl: RTL
===============

# fetch_ctrl

Fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake on behalf of the pipeline front end. It arbitrates redirect sources (interrupt, exception return, jump/branch) against an in-flight memory access, holds a fetched instruction while decode is frozen, and hands one instruction at a time to the IF/ID boundary. It sits between the hazard/CP0/branch logic and the instruction memory port.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- EXC_VECTOR, 32'h0000_4180, interrupt/exception handler entry
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- freeze  input  1  decode stalled; held instruction not consumed this cycle
- int_req  input  1  CP0 interrupt/exception request, one-cycle pulse
- eret  input  1  exception return, one-cycle pulse
- eret_addr  input  32  EPC target for eret
- jump  input  1  branch/jump taken, one-cycle pulse
- jump_addr  input  32  branch/jump target
- imem_req  output  1  instruction memory request
- imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0
- imem_ack  input  1  memory completed request this cycle; imem_rdata valid
- imem_rdata  input  32  fetched word
- instr_valid  output  1  instr/instr_pc hold a live instruction
- instr  output  32  fetched instruction
- instr_pc  output  32  address of instr
- fetch_adel  output  1  misaligned fetch flag (see Configuration)

## Operation
- States: BOOT, FETCH, HOLD.
- BOOT: entered on reset; imem_req=0; pc=RESET_PC; next cycle → FETCH.
- FETCH: imem_req=1, imem_addr=pc. Without ack: stay; redirects are latched into pending register. On ack:
  - if a redirect is pending or present this cycle: drop imem_rdata, pc←target, clear pending, stay FETCH, instr_valid stays 0.
  - else: instr←imem_rdata, instr_pc←pc, instr_valid←1, pc←pc+4, → HOLD.
- HOLD: imem_req=0, instr_valid=1, outputs stable.
  - int_req or eret: squash held instruction (instr_valid←0), pc←target, → FETCH.
  - jump: pc←jump_addr; held instruction is the delay slot and is not squashed; leaves HOLD only when freeze=0 (instr_valid←0, → FETCH); while freeze=1 the target waits in pc.
  - no redirect, freeze=0: instruction consumed; instr_valid←0, → FETCH.
  - no redirect, freeze=1: stay.
- Redirect priority in same cycle: int_req > eret > jump. Pending register keeps highest priority seen; equal priority → newest wins; int_req target is EXC_VECTOR.
- In-flight access is never aborted: imem_addr must not change until ack.
- pc+4 wraps modulo 2^32.

## Timing
- Reset values: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_adel=0, pending cleared.
- Reset asserted mid-fetch: immediate return to BOOT; late imem_ack ignored.
- imem_ack may come in the same cycle as imem_req (zero wait); instr_valid rises the next cycle.
- Minimum throughput: one instruction per 2 cycles (FETCH, HOLD).
- Redirect-to-request latency: redirect in HOLD → imem_addr=target next cycle; redirect in FETCH → target requested the cycle after ack.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: in FETCH, if pc[1:0]≠0, no memory request is issued; instead instr←0 (nop), instr_pc←pc, instr_valid←1, fetch_adel←1, → HOLD; fetch_adel clears with instr_valid. pc is not incremented (next normal fetch follows a redirect).
- Not defined: fetch_adel tied 0; pc[1:0] driven unchanged on imem_addr.

## Test plan
- Reset release, imem_ack=1 each request cycle, rdata=address → instr_pc sequence 0x3000, 0x3004, 0x3008, instr_valid high every second cycle.
- imem_ack delayed 3 cycles, jump=1 to 0x3100 in second wait cycle → imem_addr stays 0x3000 until ack, data dropped, next request at 0x3100, no instr_valid for 0x3000.
- Same cycle int_req, eret(0x3200), jump(0x3300) during FETCH → next request 0x4180.
- HOLD at instr_pc 0x3004, freeze=1 for 4 cycles, jump to 0x3400 in cycle 2 → instr stays valid until freeze drops, then request 0x3400.
- HOLD with freeze=1, int_req pulse → instr_valid drops next cycle, request 0x4180.
- With FETCH_ALIGN_CHECK_EN, eret to 0x3002 → no imem_req, instr_valid=1, instr=0, instr_pc=0x3002, fetch_adel=1.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and instruction-memory handshake sequencer (BOOT/FETCH/HOLD); optional misaligned-fetch trap under `FETCH_ALIGN_CHECK_EN
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_freeze,
  input  logic        i_int_req,
  input  logic        i_eret,
  input  logic [31:0] i_eret_addr,
  input  logic        i_jump,
  input  logic [31:0] i_jump_addr,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_fetch_adel
);
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_t;
  state_t      r_state, w_nxt_state;
  logic [31:0] r_pc, w_nxt_pc;
  logic        r_pend_vld, w_nxt_pend_vld;
  logic [1:0]  r_pend_pri, w_nxt_pend_pri;
  logic [31:0] r_pend_addr, w_nxt_pend_addr;
  logic        r_valid, w_nxt_valid;
  logic [31:0] r_instr, w_nxt_instr;
  logic [31:0] r_instr_pc, w_nxt_instr_pc;
  logic        r_adel, w_nxt_adel;
  logic        w_cur_vld, w_take_cur, w_red_vld, w_misal, w_done;
  logic [1:0]  w_cur_pri;
  logic [31:0] w_cur_addr, w_red_addr;
  // Same-cycle redirect priority: interrupt > eret > jump
  assign w_cur_vld  = i_int_req | i_eret | i_jump;
  assign w_cur_pri  = i_int_req ? 2'd2 : i_eret ? 2'd1 : 2'd0;
  assign w_cur_addr = i_int_req ? EXC_VECTOR : i_eret ? i_eret_addr : i_jump_addr;
  // A new redirect replaces the pending one unless the pending one outranks it
  assign w_take_cur = w_cur_vld & (~r_pend_vld | (w_cur_pri >= r_pend_pri));
  assign w_red_vld  = r_pend_vld | w_cur_vld;
  assign w_red_addr = w_take_cur ? w_cur_addr : r_pend_addr;
`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misal = (r_state == S_FETCH) && (r_pc[1:0] != 2'b00);
`else
  assign w_misal = 1'b0;
`endif
  assign w_done        = w_misal | i_imem_ack;
  assign o_imem_req    = (r_state == S_FETCH) & ~w_misal;
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = r_valid;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_fetch_adel  = r_adel;
  // Next-state and datapath updates; every register holds unless a branch below changes it
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_pc        = r_pc;
    w_nxt_pend_vld  = r_pend_vld;
    w_nxt_pend_pri  = r_pend_pri;
    w_nxt_pend_addr = r_pend_addr;
    w_nxt_valid     = r_valid;
    w_nxt_instr     = r_instr;
    w_nxt_instr_pc  = r_instr_pc;
    w_nxt_adel      = r_adel;
    case (r_state)
      S_BOOT: w_nxt_state = S_FETCH;
      S_FETCH: begin
        if (!w_done) begin
          w_nxt_pend_vld  = w_red_vld;
          w_nxt_pend_pri  = w_take_cur ? w_cur_pri : r_pend_pri;
          w_nxt_pend_addr = w_red_addr;
        end else if (w_red_vld) begin
          w_nxt_pc       = w_red_addr;
          w_nxt_pend_vld = 1'b0;
        end else begin
          w_nxt_instr    = w_misal ? 32'h0 : i_imem_rdata;
          w_nxt_instr_pc = r_pc;
          w_nxt_valid    = 1'b1;
          w_nxt_adel     = w_misal;
          w_nxt_pc       = w_misal ? r_pc : r_pc + 32'd4;
          w_nxt_state    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_int_req | i_eret) begin
          w_nxt_pc    = w_cur_addr;
          w_nxt_valid = 1'b0;
          w_nxt_adel  = 1'b0;
          w_nxt_state = S_FETCH;
        end else begin
          w_nxt_pc = i_jump ? i_jump_addr : r_pc;
          if (!i_freeze) begin
            w_nxt_valid = 1'b0;
            w_nxt_adel  = 1'b0;
            w_nxt_state = S_FETCH;
          end
        end
      end
      default: w_nxt_state = S_BOOT;
    endcase
  end
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_BOOT;
    else r_state <= w_nxt_state;
  // PC, pending redirect and IF/ID holding registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pc        <= RESET_PC;
      r_pend_vld  <= 1'b0;
      r_pend_pri  <= 2'd0;
      r_pend_addr <= 32'h0;
      r_valid     <= 1'b0;
      r_instr     <= 32'h0;
      r_instr_pc  <= 32'h0;
      r_adel      <= 1'b0;
    end else begin
      r_pc        <= w_nxt_pc;
      r_pend_vld  <= w_nxt_pend_vld;
      r_pend_pri  <= w_nxt_pend_pri;
      r_pend_addr <= w_nxt_pend_addr;
      r_valid     <= w_nxt_valid;
      r_instr     <= w_nxt_instr;
      r_instr_pc  <= w_nxt_instr_pc;
      r_adel      <= w_nxt_adel;
    end
endmodule
